// File: rtl/sevenseg_capture.sv
// sevenseg_capture: debounce a scanned 3-digit seven-segment display and convert it to binary
module sevenseg_capture #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg,
  input  logic [2:0] ca,
  output logic [9:0] value,
  output logic       valid,
  output logic       over,
  output logic       err
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  typedef enum logic [1:0] {COLLECT, MUL1, MUL2, DONE} state_t;
  state_t state_q, state_d;
  logic [6:0] seg_q;
  logic [2:0] ca_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0][3:0] dig_q, dig_d;
  logic [2:0] flg_q, flg_d;
  logic [9:0] acc_q, acc_d, value_q;
  logic over_q, legal, accept, store;
  logic [3:0] dec;
  // cnt_q always describes how long the current sample_q has been held
  assign cnt_d = (seg != seg_q || ca != ca_q) ? '0 : (cnt_q == CW'(STABLE_CYCLES)) ? cnt_q : cnt_q + 1'b1;
  assign accept = state_q == COLLECT && cnt_q == CW'(STABLE_CYCLES - 1) && $onehot(~ca_q);
  assign store = accept && legal;
  assign err = accept && !legal;
  assign valid = state_q == DONE;
  assign value = valid ? acc_q : value_q;
  assign over = valid ? (acc_q > 10'd255) : over_q;
  // segment pattern to BCD digit
  always_comb begin
    dec = 4'd0;
    legal = 1'b1;
    case (seg_q)
      7'h40: dec = 4'd0;
      7'h79: dec = 4'd1;
      7'h24: dec = 4'd2;
      7'h30: dec = 4'd3;
      7'h19: dec = 4'd4;
      7'h12: dec = 4'd5;
      7'h02: dec = 4'd6;
      7'h78: dec = 4'd7;
      7'h00: dec = 4'd8;
      7'h10: dec = 4'd9;
      default: legal = 1'b0;
    endcase
  end
  // digit collection and the two multiply-accumulate steps
  always_comb begin
    state_d = state_q;
    flg_d = flg_q;
    dig_d = dig_q;
    acc_d = acc_q;
    case (state_q)
      COLLECT: begin
        if (store) begin
          flg_d = flg_q | ~ca_q;
          for (int i = 0; i < 3; i++) if (!ca_q[i]) dig_d[i] = dec;
        end else if (err) flg_d = '0;
        if (&flg_d) state_d = MUL1;
      end
      MUL1: begin
        acc_d = {6'd0, dig_q[2]} * 10'd10 + {6'd0, dig_q[1]};
        state_d = MUL2;
      end
      MUL2: begin
        acc_d = acc_q * 10'd10 + {6'd0, dig_q[0]};
        state_d = DONE;
      end
      DONE: begin
        flg_d = '0;
        state_d = COLLECT;
      end
    endcase
  end
  // sample registers and all state
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q <= 7'h7F;
      ca_q <= 3'b111;
      cnt_q <= '0;
      state_q <= COLLECT;
      flg_q <= '0;
      dig_q <= '0;
      acc_q <= '0;
      value_q <= '0;
      over_q <= 1'b0;
    end else begin
      seg_q <= seg;
      ca_q <= ca;
      cnt_q <= cnt_d;
      state_q <= state_d;
      flg_q <= flg_d;
      dig_q <= dig_d;
      acc_q <= acc_d;
      value_q <= value;
      over_q <= over;
    end
  end
endmodule
